// File: rtl/des_crypt_iter.sv
// des_crypt_iter -- iterative DES data path (IP, 16 Feistel rounds, FP).
//
// One block in flight at a time. A block is accepted on in_valid & in_ready.
// One Feistel round runs per clock, and the result is held on a registered
// valid/ready output. Encrypt versus decrypt is chosen only by the order in
// which the subkeys arrive; subkeys_1 is always applied first.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   subkeys_1..subkeys_16   48-bit round subkeys, bit 1 = MSB
//   subkeys_valid           subkeys stable (from generator)
//   key_parity_error        generator parity flag (used only with macro)
//   in_data_64/in_valid     input block, bit 1 = MSB
//   in_ready                block may be accepted (combinational on subkeys)
//   out_data_64/out_valid   registered result
//   out_ready               consumer accepts result
//   busy                    block in flight (ROUND or DONE)
//   abort_pulse             one-cycle pulse when an in-flight block is dropped
//
// Configuration macro: DES_CRYPT_ITER_PARITY_GATE_EN
//   defined   : key_parity_error gates in_ready and aborts a running block
//   undefined : key_parity_error is ignored

// Combinational DES round function f(R, K) = P(S(E(R) ^ K)).
module des_feistel_f (
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] f_o
);
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box is 64 nibbles, row-major, first entry in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  logic [47:0] e_exp;
  logic [47:0] x_mix;
  logic [31:0] s_out;

  for (genvar i = 0; i < 48; i = i + 1) begin : g_e
    assign e_exp[47-i] = r_i[32-E_TAB[i]];
  end

  assign x_mix = e_exp ^ k_i;

  for (genvar j = 0; j < 8; j = j + 1) begin : g_s
    logic [5:0] six;
    logic [5:0] idx;
    assign six = x_mix[47-6*j -: 6];
    // row = outer bits, column = inner four bits
    assign idx = {six[5], six[0], six[4:1]};
    // entry k lives at bit offset 4*(63-k), i.e. {~k, 2'b00}
    assign s_out[31-4*j -: 4] = SBOX[j][{~idx, 2'b00} +: 4];
  end

  for (genvar i = 0; i < 32; i = i + 1) begin : g_p
    assign f_o[31-i] = s_out[32-P_TAB[i]];
  end
endmodule

module des_crypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] subkeys_1,
  input  logic [47:0] subkeys_2,
  input  logic [47:0] subkeys_3,
  input  logic [47:0] subkeys_4,
  input  logic [47:0] subkeys_5,
  input  logic [47:0] subkeys_6,
  input  logic [47:0] subkeys_7,
  input  logic [47:0] subkeys_8,
  input  logic [47:0] subkeys_9,
  input  logic [47:0] subkeys_10,
  input  logic [47:0] subkeys_11,
  input  logic [47:0] subkeys_12,
  input  logic [47:0] subkeys_13,
  input  logic [47:0] subkeys_14,
  input  logic [47:0] subkeys_15,
  input  logic [47:0] subkeys_16,
  input  logic        subkeys_valid,
  input  logic        key_parity_error,
  input  logic [63:0] in_data_64,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data_64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        abort_pulse
);
  // state | meaning
  // IDLE  | waiting for a block; in_ready follows key validity
  // ROUND | one Feistel round per clock, rnd_q = round index 0..15
  // DONE  | result held on out_data_64 until out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        abort_q, abort_d;

  logic        keys_ok;
  logic [47:0] sk_arr [16];
  logic [47:0] k_sel;
  logic [31:0] f_val;
  logic [31:0] r_next;
  logic [63:0] ip_blk;
  logic [63:0] pre_out;
  logic [63:0] fp_blk;

`ifdef DES_CRYPT_ITER_PARITY_GATE_EN
  assign keys_ok = subkeys_valid & ~key_parity_error;
`else
  logic unused_parity;
  assign unused_parity = key_parity_error;
  assign keys_ok       = subkeys_valid;
`endif

  assign sk_arr[0]  = subkeys_1;
  assign sk_arr[1]  = subkeys_2;
  assign sk_arr[2]  = subkeys_3;
  assign sk_arr[3]  = subkeys_4;
  assign sk_arr[4]  = subkeys_5;
  assign sk_arr[5]  = subkeys_6;
  assign sk_arr[6]  = subkeys_7;
  assign sk_arr[7]  = subkeys_8;
  assign sk_arr[8]  = subkeys_9;
  assign sk_arr[9]  = subkeys_10;
  assign sk_arr[10] = subkeys_11;
  assign sk_arr[11] = subkeys_12;
  assign sk_arr[12] = subkeys_13;
  assign sk_arr[13] = subkeys_14;
  assign sk_arr[14] = subkeys_15;
  assign sk_arr[15] = subkeys_16;

  assign k_sel = sk_arr[rnd_q];

  des_feistel_f u_f (
    .r_i (r_q),
    .k_i (k_sel),
    .f_o (f_val)
  );

  assign r_next = l_q ^ f_val;
  // Final round: the halves are swapped before FP, so R16 goes on top.
  assign pre_out = {r_next, r_q};

  for (genvar i = 0; i < 64; i = i + 1) begin : g_perm
    assign ip_blk[63-i] = in_data_64[64-IP_TAB[i]];
    assign fp_blk[63-i] = pre_out[64-FP_TAB[i]];
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    abort_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && keys_ok) begin
          l_d     = ip_blk[63:32];
          r_d     = ip_blk[31:0];
          rnd_d   = 4'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (!keys_ok) begin
          // keys went away mid-block: the block is dropped, source resends
          rnd_d   = 4'd0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          l_d   = r_q;
          r_d   = r_next;
          rnd_d = rnd_q + 4'd1;
          if (rnd_q == 4'd15) begin
            out_data_d  = fp_blk;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      abort_q     <= abort_d;
    end
  end

  assign in_ready    = (state_q == IDLE) & keys_ok;
  assign out_data_64 = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q == ROUND) | (state_q == DONE);
  assign abort_pulse = abort_q;
endmodule

// File: tb/tb_des_crypt_iter.sv
module tb_des_crypt_iter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] sk [16];
  logic        subkeys_valid;
  logic        key_parity_error;
  logic [63:0] in_data_64;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data_64;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        abort_pulse;

  int pass_cnt;
  int total_cnt;

  always #5 clk = ~clk;

  des_crypt_iter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .subkeys_1        (sk[0]),
    .subkeys_2        (sk[1]),
    .subkeys_3        (sk[2]),
    .subkeys_4        (sk[3]),
    .subkeys_5        (sk[4]),
    .subkeys_6        (sk[5]),
    .subkeys_7        (sk[6]),
    .subkeys_8        (sk[7]),
    .subkeys_9        (sk[8]),
    .subkeys_10       (sk[9]),
    .subkeys_11       (sk[10]),
    .subkeys_12       (sk[11]),
    .subkeys_13       (sk[12]),
    .subkeys_14       (sk[13]),
    .subkeys_15       (sk[14]),
    .subkeys_16       (sk[15]),
    .subkeys_valid    (subkeys_valid),
    .key_parity_error (key_parity_error),
    .in_data_64       (in_data_64),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_data_64      (out_data_64),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .abort_pulse      (abort_pulse)
  );

  // ---------------- reference DES (FIPS 46-3 tables) ----------------
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
    44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  logic [47:0] mk [16];  // model key schedule, K1..K16

  task automatic ref_schedule(input logic [63:0] key);
    logic [27:0] c, d;
    logic [55:0] cd;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1_T[i]];
      d[27-i] = key[64-PC1_T[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) mk[r][47-i] = cd[56-PC2_T[i]];
    end
  endtask

  task automatic load_keys(input bit enc);
    for (int i = 0; i < 16; i++) sk[i] = enc ? mk[i] : mk[15-i];
  endtask

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    int six, row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      six = int'(x[47-6*j -: 6]);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s[31-4*j -: 4] = 4'(SB[j][row][col]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  // Applies the subkeys currently driven on sk[], first entry first.
  function automatic logic [63:0] ref_des(input logic [63:0] blk);
    logic [63:0] p, pre, o;
    logic [31:0] l, r, t;
    for (int i = 0; i < 64; i++) p[63-i] = blk[64-IP_T[i]];
    l = p[63:32];
    r = p[31:0];
    for (int rr = 0; rr < 16; rr++) begin
      t = r;
      r = l ^ ref_f(r, sk[rr]);
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) o[63-i] = pre[64-FP_T[i]];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Returns at the negedge after the accepting posedge.
  task automatic accept_block(input logic [63:0] d, output bit ok, output int waited);
    @(negedge clk);
    in_data_64 = d;
    in_valid   = 1'b1;
    waited     = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = in_ready;
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    in_data_64 = {$urandom(), $urandom()};
  endtask

  // lat = posedges after accept until out_valid is seen (bounded).
  task automatic wait_out(output int lat, output logic [63:0] data, output bit seen);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    seen = out_valid;
    data = out_data_64;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; subkeys_valid = 1'b0; key_parity_error = 1'b0;
    in_valid = 1'b0; in_data_64 = '0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sk[i] = '0;
    #3;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data_64 !== 64'h0) $display("FAIL reset_out_data got %h want 0", out_data_64); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (abort_pulse !== 1'b0) $display("FAIL reset_abort got %b want 0", abort_pulse); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_nokeys got %b want 0", in_ready); else pass_cnt++;
    subkeys_valid = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_keys got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_encrypt_kat();
    bit ok, seen; int waited, lat; logic [63:0] got;
    ref_schedule(64'h133457799BBCDFF1);
    load_keys(1'b1);
    out_ready = 1'b1;
    accept_block(64'h0123456789ABCDEF, ok, waited);
    total_cnt++; if (ok !== 1'b1) $display("FAIL enc_accept got %b want 1", ok); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL enc_busy got %b want 1", busy); else pass_cnt++;
    wait_out(lat, got, seen);
    total_cnt++; if (lat !== 16) $display("FAIL enc_latency got %0d want 16", lat); else pass_cnt++;
    total_cnt++; if (got !== 64'h85E813540F0AB405) $display("FAIL enc_kat got %h want 85e813540f0ab405", got); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL enc_handshake_clear got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_decrypt_kat();
    bit ok, seen; int waited, lat; logic [63:0] got;
    ref_schedule(64'h133457799BBCDFF1);
    load_keys(1'b0);
    out_ready = 1'b1;
    accept_block(64'h85E813540F0AB405, ok, waited);
    wait_out(lat, got, seen);
    total_cnt++; if (seen !== 1'b1) $display("FAIL dec_out_valid got %b want 1", seen); else pass_cnt++;
    total_cnt++; if (got !== 64'h0123456789ABCDEF) $display("FAIL dec_kat got %h want 0123456789abcdef", got); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok, seen; int waited, lat, bad_hold, bad_ready, hs; logic [63:0] held;
    ref_schedule(64'h133457799BBCDFF1);
    load_keys(1'b1);
    out_ready = 1'b0;
    accept_block(64'h0123456789ABCDEF, ok, waited);
    wait_out(lat, held, seen);
    total_cnt++; if (held !== 64'h85E813540F0AB405) $display("FAIL bp_data got %h want 85e813540f0ab405", held); else pass_cnt++;
    bad_hold = 0; bad_ready = 0;
    in_valid = 1'b1; in_data_64 = {$urandom(), $urandom()};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_data_64 !== held || out_valid !== 1'b1) bad_hold++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    in_valid = 1'b0;
    total_cnt++; if (bad_hold !== 0) $display("FAIL bp_hold bad_cycles %0d want 0", bad_hold); else pass_cnt++;
    total_cnt++; if (bad_ready !== 0) $display("FAIL bp_in_ready bad_cycles %0d want 0", bad_ready); else pass_cnt++;
    out_ready = 1'b1;
    hs = (out_valid && out_ready) ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_next_accept got %b want 1", in_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk);
      @(negedge clk);
    end
    total_cnt++; if (hs !== 1) $display("FAIL bp_handshakes got %0d want 1", hs); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok, seen; int waited, lat; logic [63:0] got, d1, d2, e1, e2;
    ref_schedule({$urandom(), $urandom()});
    load_keys(1'b1);
    d1 = {$urandom(), $urandom()}; d2 = {$urandom(), $urandom()};
    e1 = ref_des(d1); e2 = ref_des(d2);
    out_ready = 1'b1;
    accept_block(d1, ok, waited);
    wait_out(lat, got, seen);
    total_cnt++; if (got !== e1) $display("FAIL b2b_first got %h want %h", got, e1); else pass_cnt++;
    accept_block(d2, ok, waited);
    total_cnt++; if (waited !== 0 || ok !== 1'b1) $display("FAIL b2b_accept_gap got %0d want 0", waited); else pass_cnt++;
    wait_out(lat, got, seen);
    total_cnt++; if (lat !== 16) $display("FAIL b2b_latency got %0d want 16", lat); else pass_cnt++;
    total_cnt++; if (got !== e2) $display("FAIL b2b_second got %h want %h", got, e2); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit ok, seen; int waited, lat, ov; logic [63:0] got, d, e;
    ref_schedule({$urandom(), $urandom()});
    load_keys(1'b1);
    d = {$urandom(), $urandom()}; e = ref_des(d);
    out_ready = 1'b1;
    accept_block(d, ok, waited);
    repeat (7) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_pre_busy got %b want 1", busy); else pass_cnt++;
    subkeys_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (abort_pulse !== 1'b1) $display("FAIL abort_pulse got %b want 1", abort_pulse); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (abort_pulse !== 1'b0) $display("FAIL abort_pulse_width got %b want 0", abort_pulse); else pass_cnt++;
    ov = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ov++;
      @(negedge clk);
    end
    total_cnt++; if (ov !== 0) $display("FAIL abort_no_output got %0d want 0", ov); else pass_cnt++;
    subkeys_valid = 1'b1;
    accept_block(d, ok, waited);
    wait_out(lat, got, seen);
    total_cnt++; if (got !== e || lat !== 16) $display("FAIL abort_resend got %h lat %0d want %h lat 16", got, lat, e); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit ok; int waited, ov;
    ref_schedule({$urandom(), $urandom()});
    load_keys(1'b1);
    out_ready = 1'b1;
    accept_block({$urandom(), $urandom()}, ok, waited);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data_64 !== 64'h0) $display("FAIL rst_mid_out_data got %h want 0", out_data_64); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (abort_pulse !== 1'b0) $display("FAIL rst_mid_abort got %b want 0", abort_pulse); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    ov = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    total_cnt++; if (ov !== 0) $display("FAIL rst_mid_no_output got %0d want 0", ov); else pass_cnt++;
  endtask

  task automatic test_parity();
`ifdef DES_CRYPT_ITER_PARITY_GATE_EN
    bit ok; int waited, rdy, bsy;
    ref_schedule(64'h133457799BBCDFF0);
    load_keys(1'b1);
    key_parity_error = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data_64 = 64'h0123456789ABCDEF;
    rdy = 0; bsy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) rdy++;
      if (busy) bsy++;
    end
    in_valid = 1'b0;
    total_cnt++; if (rdy !== 0) $display("FAIL parity_in_ready got %0d cycles want 0", rdy); else pass_cnt++;
    total_cnt++; if (bsy !== 0) $display("FAIL parity_busy got %0d cycles want 0", bsy); else pass_cnt++;
    key_parity_error = 1'b0;
    ref_schedule(64'h133457799BBCDFF1);
    load_keys(1'b1);
    accept_block(64'h0123456789ABCDEF, ok, waited);
    repeat (5) @(posedge clk);
    @(negedge clk);
    key_parity_error = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (abort_pulse !== 1'b1 || busy !== 1'b0) $display("FAIL parity_abort got pulse %b busy %b want 1 0", abort_pulse, busy); else pass_cnt++;
    key_parity_error = 1'b0;
    @(negedge clk);
`else
    bit ok, seen; int waited, lat; logic [63:0] got, e;
    ref_schedule(64'h133457799BBCDFF0);
    load_keys(1'b1);
    e = ref_des(64'h0123456789ABCDEF);
    key_parity_error = 1'b1;
    out_ready = 1'b1;
    accept_block(64'h0123456789ABCDEF, ok, waited);
    total_cnt++; if (ok !== 1'b1) $display("FAIL parity_ignored_accept got %b want 1", ok); else pass_cnt++;
    wait_out(lat, got, seen);
    total_cnt++; if (got !== e) $display("FAIL parity_ignored_data got %h want %h", got, e); else pass_cnt++;
    @(negedge clk);
    key_parity_error = 1'b0;
`endif
  endtask

  task automatic test_random();
    bit ok, seen, stable; int waited, lat, dly; logic [63:0] key, pt, e, got, got2;
    for (int it = 0; it < 12; it++) begin
      key = {$urandom(), $urandom()};
      pt  = {$urandom(), $urandom()};
      dly = $urandom_range(0, 3);
      ref_schedule(key);
      load_keys(1'b1);
      e = ref_des(pt);
      out_ready = 1'b0;
      accept_block(pt, ok, waited);
      wait_out(lat, got, seen);
      stable = 1'b1;
      for (int i = 0; i < dly; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (out_data_64 !== got || out_valid !== 1'b1) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total_cnt++; if (got !== e || !seen) $display("FAIL rand_enc[%0d] got %h want %h", it, got, e); else pass_cnt++;
      total_cnt++; if (stable !== 1'b1) $display("FAIL rand_hold[%0d] got %b want 1", it, stable); else pass_cnt++;
      load_keys(1'b0);
      accept_block(got, ok, waited);
      wait_out(lat, got2, seen);
      total_cnt++; if (got2 !== pt) $display("FAIL rand_roundtrip[%0d] got %h want %h", it, got2, pt); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_encrypt_kat();
    test_decrypt_kat();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_midop();
    test_parity();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/des_crypt_iter.md
# des_crypt_iter

Iterative DES data path that sits directly downstream of the subkey generator. It consumes the sixteen 48-bit round subkeys and their valid flag, and accepts 64-bit blocks over a valid/ready handshake. Each block gets IP, sixteen Feistel rounds (one per clock) and FP, and the result goes out on a registered valid/ready output. Encrypt/decrypt is decided entirely by subkey ordering upstream; this block always applies subkeys_1 first.

## Interface
- No parameters; all widths are fixed by FIPS 46-3.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- subkeys_1 … subkeys_16  in  48 each  round subkeys; bit 1 is the MSB.
- subkeys_valid  in  1  subkeys are stable; driven from the generator's subkeys_16_valid.
- key_parity_error  in  1  from the generator's parity_check_error; used only under the configuration macro.
- in_data_64  in  64  plaintext or ciphertext block, bits [1:64], bit 1 is the MSB.
- in_valid  in  1  in_data_64 is valid.
- in_ready  out  1  the block can accept an input.
- out_data_64  out  64  result block, bits [1:64].
- out_valid  out  1  out_data_64 is valid.
- out_ready  in  1  the consumer accepts the output.
- busy  out  1  a block is in flight (state is ROUND or DONE).
- abort_pulse  out  1  one-cycle pulse when an in-flight block is discarded.

## Operation
- The round function (E expansion, S1–S8, P) is the combinational submodule des_feistel_f, delivered alongside this block. Registers l_32/r_32 and the round counter rnd (4 bits) are local to this block.
- State machine, encoded 2 bits:
  - IDLE: in_ready = subkeys_valid (see Configuration). On in_valid & in_ready: {l_32, r_32} <= IP(in_data_64), rnd <= 0, go to ROUND.
  - ROUND: each cycle computes l <= r and r <= l ^ f(r, subkeys_{rnd+1}), then rnd <= rnd + 1.
    - When rnd == 15, the round result is swapped (R16‖L16) and passed through FP into out_data_64. out_valid <= 1, go to DONE.
  - DONE: out_data_64 is held stable. When out_valid & out_ready: out_valid <= 0, go to IDLE.
- in_ready is 0 in ROUND and DONE; only one block is in flight at a time.
- Abort: if subkeys_valid is 0 in any cycle while in ROUND:
  - go to IDLE, rnd <= 0, pulse abort_pulse, leave out_valid at 0.
  - The input block is lost; the upstream source must resend it.
- Once in DONE, a drop of subkeys_valid does not affect the held output.
- rnd wraps 15→0 only on the transition to DONE; it is never used outside ROUND.
- Reset values: state IDLE, l_32 = r_32 = 0, rnd = 0, out_data_64 = 0, out_valid = 0, busy = 0, abort_pulse = 0. in_ready then follows subkeys_valid combinationally.
- Reset asserted mid-operation returns to the reset values immediately. No output is produced for the in-flight block.

## Timing
- Input accept at rising edge T (in_valid & in_ready both high).
- Rounds execute at edges T+1 … T+16. out_valid is high after edge T+16, giving a latency of 16 cycles from accept to out_valid.
- Earliest output handshake is at edge T+17, and the next accept at edge T+18. Minimum throughput is 18 cycles per block.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data_64 and out_valid hold, and in_ready stays 0.
- in_ready depends combinationally on subkeys_valid (and on key_parity_error under the macro). All other outputs are registered.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- Macro: DES_CRYPT_ITER_PARITY_GATE_EN.
- Defined: in_ready = IDLE & subkeys_valid & ~key_parity_error.
  - A parity error rising during ROUND is treated exactly like a subkeys_valid drop: abort and pulse abort_pulse.
- Undefined: key_parity_error is ignored (port kept, unconnected internally). Keys with bad parity are processed normally.

## Test plan
- Encrypt known answer: key 133457799BBCDFF1 (subkeys from the generator, encrypt = 1), in_data_64 0123456789ABCDEF, out_ready held 1.
  - Requires out_data_64 = 85E813540F0AB405, with out_valid rising exactly 16 cycles after accept.
- Decrypt: same key with encrypt = 0 (reversed subkeys), input 85E813540F0AB405.
  - Requires 0123456789ABCDEF.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises.
  - out_data_64 stays constant and in_ready stays 0.
  - On releasing out_ready, exactly one handshake occurs and the next accept is possible one cycle later.
- Abort: drop subkeys_valid at round 7.
  - Requires a one-cycle abort_pulse, state back to IDLE, and no out_valid.
  - After subkeys_valid returns, the same block encrypts correctly.
- Reset at round 10: assert rst_n = 0 asynchronously.
  - All outputs go to zero immediately, and busy = 0.
- Parity gate (macro defined): key 133457799BBCDFF0 (bad parity).
  - Requires in_ready = 0 throughout.
  - With the macro undefined, the same key is accepted and processed.
